// File: rtl/stream_fifo_if.sv
// Valid/ready stream handshake bundle: upstream (i_*) and downstream (o_*) sides.
interface stream_fifo_if #(
  parameter int WIDTH = 32
);
  logic             i_val;
  logic             i_rdy;
  logic [WIDTH-1:0] i_data;
  logic             o_val;
  logic             o_rdy;
  logic [WIDTH-1:0] o_data;

  // master: the environment that sources words and sinks the head word
  modport master (
    output i_val, i_data, o_rdy,
    input  i_rdy, o_val, o_data
  );

  // slave: the FIFO itself
  modport slave (
    input  i_val, i_data, o_rdy,
    output i_rdy, o_val, o_data
  );
endinterface

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with flush and almost-full flag.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  stream_fifo_if.slave             s,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // i_rdy deliberately ignores o_rdy: a full FIFO never accepts in the popping cycle
  assign s.i_rdy     = (count != CW'(DEPTH)) && !flush;
  assign s.o_val     = (count != '0);
  assign s.o_data    = s.o_val ? storage[rd_ptr] : '0;
  assign almost_full = (count >= CW'(AFULL));

  assign push = s.i_val && s.i_rdy;
  assign pop  = s.o_val && s.o_rdy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // storage is not reset; outputs mask it whenever count is zero
  always_ff @(posedge clk) begin
    if (push && !rst) storage[wr_ptr] <= s.i_data;
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Randomized and directed checks of stream_fifo against a queue-based reference model.
module tb_stream_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;
  int         n_err = 0;
  int         n_chk = 0;
  bit         armed = 1'b0;
  logic [7:0] q [$];

  stream_fifo_if #(.WIDTH(8)) bus ();

  stream_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s           (bus.slave),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model mid-cycle, then advance both.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl, input logic rs);
    logic exp_rdy;
    logic do_pop;
    rst        = rs;
    flush      = fl;
    bus.i_val  = iv;
    bus.i_data = d;
    bus.o_rdy  = ordy;
    @(negedge clk);
    exp_rdy = (q.size() != 4) && !fl;
    if (armed) begin
      check_val("i_rdy",       32'(bus.i_rdy),   32'(exp_rdy));
      check_val("o_val",       32'(bus.o_val),   32'(q.size() != 0));
      check_val("o_data",      32'(bus.o_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
      check_val("count",       32'(count),       32'(q.size()));
      check_val("almost_full", 32'(almost_full), 32'(q.size() >= 3));
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && ordy;
      if (do_pop) void'(q.pop_front());
      if (iv && exp_rdy) q.push_back(d);
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.i_val = 1'b0; bus.i_data = '0; bus.o_rdy = 1'b0;

    step(0, 8'h00, 0, 0, 1);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_oval",  32'(bus.o_val), 32'd0);
    check_val("rst_odata", 32'(bus.o_data), 32'd0);
    check_val("rst_irdy",  32'(bus.i_rdy), 32'd1);

    // first-word fall-through
    step(1, 8'h11, 0, 0, 0);
    check_val("fwft_oval",  32'(bus.o_val), 32'd1);
    check_val("fwft_odata", 32'(bus.o_data), 32'h11);
    check_val("fwft_count", 32'(count), 32'd1);
    step(0, 8'h00, 0, 1, 0);

    // fill to full, fifth word held off
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 3) check_val("afull_at3", 32'(almost_full), 32'd1);
    end
    step(1, 8'h05, 0, 0, 0);
    check_val("full_count", 32'(count), 32'd4);
    check_val("full_irdy",  32'(bus.i_rdy), 32'd0);
    check_val("full_afull", 32'(almost_full), 32'd1);

    // pop while full does not admit a push in the same cycle
    step(1, 8'h05, 1, 0, 0);
    check_val("fullpop_count", 32'(count), 32'd3);
    step(1, 8'h05, 0, 0, 0);
    check_val("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_order", 32'(bus.o_data), 32'(8'h02 + 8'(i)));
      step(0, 8'h00, 1, 0, 0);
    end
    step(0, 8'h00, 1, 0, 0);

    // steady-state streaming at count 2, pointers wrap
    step(1, 8'h20, 0, 0, 0);
    step(1, 8'h21, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check_val("stream_data", 32'(bus.o_data), 32'(8'h20 + 8'(i)));
      step(1, 8'h22 + 8'(i), 1, 0, 0);
      check_val("stream_count", 32'(count), 32'd2);
    end

    // flush overrides push/pop
    step(1, 8'h40, 0, 0, 0);
    check_val("pre_flush_count", 32'(count), 32'd3);
    step(1, 8'h41, 1, 1, 0);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_oval",  32'(bus.o_val), 32'd0);
    check_val("flush_odata", 32'(bus.o_data), 32'd0);
    step(0, 8'h00, 1, 0, 0);

    // reset mid-transfer
    step(1, 8'h50, 0, 0, 0);
    step(1, 8'h51, 0, 0, 0);
    step(1, 8'h52, 1, 0, 1);
    check_val("midrst_count", 32'(count), 32'd0);
    check_val("midrst_oval",  32'(bus.o_val), 32'd0);
    check_val("midrst_irdy",  32'(bus.i_rdy), 32'd1);
    step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 55),
           ($urandom_range(99) < 3), ($urandom_range(99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-003 Parameter AFULL, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-004 The clock is a single clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 flush  input  1  synchronous discard of all stored entries.
REQ-008 i_val  input  1  upstream word valid.
REQ-009 i_rdy  output  1  block can accept a word this cycle.
REQ-010 i_data  input  WIDTH  upstream word.
REQ-011 o_val  output  1  head word valid.
REQ-012 o_rdy  input  1  downstream accepts head word.
REQ-013 o_data  output  WIDTH  head word.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 almost_full  output  1  high when count >= AFULL.

Function
REQ-016 Push occurs when i_val && i_rdy; pop occurs when o_val && o_rdy.
REQ-017 i_rdy = (count != DEPTH) && !flush; combinational; no dependence on o_rdy.
REQ-018 o_val = (count != 0); o_data = storage[rd_ptr] when o_val, else all zeros.
REQ-019 First-word fall-through: a word pushed in cycle N drives o_val/o_data from cycle N+1; no same-cycle bypass.
REQ-020 Words leave in exact push order; no loss or duplication outside flush/reset.
REQ-021 Push writes i_data to storage[wr_ptr], wr_ptr increments modulo DEPTH.
REQ-022 Pop increments rd_ptr modulo DEPTH; storage content is not cleared.
REQ-023 count next = count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-024 Full (count==DEPTH): i_rdy low; a pop in that cycle does not enable a push in the same cycle; i_rdy rises the following cycle.
REQ-025 Empty (count==0): o_val low; o_rdy ignored; count never underflows.
REQ-026 Sustained throughput is one word per cycle when neither full nor empty.
REQ-027 flush high: next cycle count=0, rd_ptr=wr_ptr=0, o_val=0; flush overrides any push or pop in the same cycle; a pop presented during flush still completes downstream (o_val/o_data valid in that cycle), the entry is discarded internally.
REQ-028 almost_full, count and o_val are functions of registered state only.
REQ-029 The data path holds i_data only in storage; no output register beyond the storage array.

Reset
REQ-030 rst high at a rising edge: count=0, rd_ptr=0, wr_ptr=0; next cycle o_val=0, o_data=0, almost_full=0 (AFULL>=1), i_rdy=1 if flush low.
REQ-031 rst has priority over flush, push and pop; reset mid-transfer discards all stored words.
REQ-032 Storage array is not reset; no output depends on unreset storage while count==0.

Verification
REQ-033 WIDTH=8, DEPTH=4: push 0x11 in cycle 0, o_rdy=0 -> cycle 1 o_val=1, o_data=0x11, count=1.
REQ-034 Push 0x01..0x04 with o_rdy=0 -> count=4, i_rdy=0, almost_full=1 (AFULL=3 from count 3); 5th word 0x05 held by source, not stored.
REQ-035 Full, i_val=1 with 0x05, o_rdy=1 one cycle -> pops 0x01, no push that cycle; next cycle i_rdy=1, 0x05 pushed; drain order 0x02,0x03,0x04,0x05.
REQ-036 Count=2, i_val=1 and o_rdy=1 for 10 cycles with incrementing data -> count stays 2, one word out per cycle, order preserved, pointers wrap twice.
REQ-037 Count=3, flush=1 with i_val=1, o_rdy=1 -> next cycle count=0, o_val=0, o_data=0; pushed word not later observed.
REQ-038 Count=2, rst=1 for one cycle -> next cycle count=0, o_val=0, i_rdy=1; prior words never appear on o_data.
